// File: rtl/od_time_multi_if.sv
// ---------------------------------------------------------------------------
// od_time_multi_if
//   Bundles the sensor-side inputs and classifier outputs of od_time_multi.
//   Ports:
//     time_taken      N_CH*TIME_W packed samples, channel i at [i*TIME_W +: TIME_W]
//     sample_valid    per-channel single-cycle sample strobe
//     sensor_timeout  per-channel sensor error (highest priority)
//     near_flag       per-channel NEAR indication
//     far_flag        per-channel FAR indication
//     object_detected any channel NEAR
//     closest_ch      NEAR channel with smallest last accepted time
//     closest_valid   closest_ch is meaningful
//     dbg_state       per-channel state register, channel i at [2*i +: 2]
//   Handshake: there is no back-pressure. A sample on channel i is consumed
//   on every rising clk edge where sample_valid[i]=1; the producer holds it
//   for exactly that one cycle. Outputs are always valid after reset.
// ---------------------------------------------------------------------------
interface od_time_multi_if #(
    parameter int N_CH   = 4,
    parameter int TIME_W = 23
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*TIME_W-1:0] time_taken;
    logic [N_CH-1:0]        sample_valid;
    logic [N_CH-1:0]        sensor_timeout;
    logic [N_CH-1:0]        near_flag;
    logic [N_CH-1:0]        far_flag;
    logic                   object_detected;
    logic [CH_W-1:0]        closest_ch;
    logic                   closest_valid;
    logic [2*N_CH-1:0]      dbg_state;

    // Producer side (sensor front-end / testbench).
    modport master (
        output time_taken, sample_valid, sensor_timeout,
        input  near_flag, far_flag, object_detected, closest_ch, closest_valid, dbg_state
    );

    // Classifier side.
    modport slave (
        input  time_taken, sample_valid, sensor_timeout,
        output near_flag, far_flag, object_detected, closest_ch, closest_valid, dbg_state
    );
endinterface

// File: rtl/od_time_multi.sv
// ---------------------------------------------------------------------------
// od_time_multi
//   Multi-channel obstacle classifier. Each channel runs an IDLE/FAR/NEAR
//   state machine with debounced NEAR entry, hysteresis on NEAR exit and a
//   stale-data watchdog. The aggregate stage reports whether any channel is
//   NEAR and which NEAR channel has the smallest last accepted time.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    od_time_multi_if.slave (samples in, flags/closest/debug out)
// ---------------------------------------------------------------------------
module od_time_multi #(
    parameter int N_CH      = 4,
    parameter int TIME_W    = 23,
    parameter int NEAR_TH   = 3,
    parameter int FAR_TH    = 5,
    parameter int DEBOUNCE  = 2,
    parameter int STALE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    od_time_multi_if.slave    bus
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE + 1);
    localparam int STALE_W = $clog2(STALE_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FAR  = 2'd1,
        ST_NEAR = 2'd2
    } ch_state_t;

    logic [2*N_CH-1:0]      state_flat;
    logic [N_CH*TIME_W-1:0] time_flat;
    logic [N_CH-1:0]        near_v;
    logic [N_CH-1:0]        far_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_t          state;
        logic [CNT_W-1:0]   near_cnt;
        logic [STALE_W-1:0] stale_cnt;
        logic [TIME_W-1:0]  last_time;
        logic [TIME_W-1:0]  sample;
        logic               qual;
        logic               above_far;
        logic               debounce_done;
        logic               stale_last;
        logic               stale_sat;

        assign sample        = bus.time_taken[i*TIME_W +: TIME_W];
        assign qual          = (sample <= TIME_W'(NEAR_TH));
        assign above_far     = (sample >  TIME_W'(FAR_TH));
        assign debounce_done = ((32'(near_cnt) + 32'd1) >= 32'(DEBOUNCE));
        // True on the empty cycle that brings stale_cnt up to STALE_CYC
        // (and on every empty cycle after saturation, which is harmless).
        assign stale_last    = ((32'(stale_cnt) + 32'd1) >= 32'(STALE_CYC));
        assign stale_sat     = (32'(stale_cnt) >= 32'(STALE_CYC));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= ST_IDLE;
                near_cnt  <= '0;
                stale_cnt <= '0;
                last_time <= '0;
            end else if (bus.sensor_timeout[i]) begin
                // Sensor error wins; any simultaneous sample is dropped.
                state     <= ST_IDLE;
                near_cnt  <= '0;
                stale_cnt <= '0;
            end else if (bus.sample_valid[i]) begin
                last_time <= sample;
                stale_cnt <= '0;
                case (state)
                    ST_IDLE, ST_FAR: begin
                        if (qual && debounce_done) begin
                            state    <= ST_NEAR;
                            near_cnt <= '0;
                        end else if (qual) begin
                            state    <= ST_FAR;
                            near_cnt <= near_cnt + CNT_W'(1);
                        end else begin
                            state    <= ST_FAR;
                            near_cnt <= '0;
                        end
                    end
                    ST_NEAR: begin
                        // Exit needs only one sample beyond FAR_TH; the
                        // (NEAR_TH, FAR_TH] band holds NEAR.
                        near_cnt <= '0;
                        if (above_far) state <= ST_FAR;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        near_cnt <= '0;
                    end
                endcase
            end else begin
                if (!stale_sat) stale_cnt <= stale_cnt + STALE_W'(1);
                if (stale_last || (state == ch_state_t'(2'd3))) begin
                    state    <= ST_IDLE;
                    near_cnt <= '0;
                end
            end
        end

        assign state_flat[2*i +: 2]         = state;
        assign time_flat[i*TIME_W +: TIME_W] = last_time;
        assign near_v[i]                    = (state == ST_NEAR);
        assign far_v[i]                     = (state == ST_FAR);
    end

    // Closest NEAR channel: strict less-than keeps the lowest index on ties.
    logic              found;
    logic [TIME_W-1:0] best_t;
    logic [CH_W-1:0]   best_i;

    always_comb begin
        found  = 1'b0;
        best_t = '0;
        best_i = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (near_v[i] && (!found || (time_flat[i*TIME_W +: TIME_W] < best_t))) begin
                found  = 1'b1;
                best_t = time_flat[i*TIME_W +: TIME_W];
                best_i = CH_W'(i);
            end
        end
    end

    logic [CH_W-1:0] closest_ch_q;
    logic            closest_valid_q;

    // closest_ch keeps its last value while no channel is NEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            closest_ch_q    <= '0;
            closest_valid_q <= 1'b0;
        end else begin
            closest_valid_q <= found;
            if (found) closest_ch_q <= best_i;
        end
    end

    assign bus.near_flag       = near_v;
    assign bus.far_flag        = far_v;
    assign bus.object_detected = |near_v;
    assign bus.closest_ch      = closest_ch_q;
    assign bus.closest_valid   = closest_valid_q;
    assign bus.dbg_state       = state_flat;
endmodule

// File: tb/tb_od_time_multi.sv
// ---------------------------------------------------------------------------
// tb_od_time_multi
//   Directed bench for od_time_multi with default parameters. The driver
//   applies one cycle of stimulus on the falling edge and queues the outputs
//   expected after the following rising edge; the monitor pops one entry
//   per rising edge (sampled 1 ns later) and compares.
//   Expected entry layout: {near[3:0], far[3:0], closest_valid, closest_ch[1:0]}.
// ---------------------------------------------------------------------------
module tb_od_time_multi;
    localparam int N_CH   = 4;
    localparam int TIME_W = 23;
    localparam int EXP_W  = 11;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   step_no;

    logic [EXP_W-1:0] exp_q[$];

    od_time_multi_if #(.N_CH(N_CH), .TIME_W(TIME_W)) bus ();

    od_time_multi #(
        .N_CH(N_CH), .TIME_W(TIME_W), .NEAR_TH(3), .FAR_TH(5),
        .DEBOUNCE(2), .STALE_CYC(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic put(input int ch, input logic [TIME_W-1:0] t);
        bus.sample_valid[ch]               = 1'b1;
        bus.time_taken[ch*TIME_W +: TIME_W] = t;
    endtask

    task automatic cyc(input logic [3:0] en, input logic [3:0] ef,
                       input logic ecv, input logic [1:0] ecch);
        exp_q.push_back({en, ef, ecv, ecch});
        @(posedge clk);
        @(negedge clk);
        bus.sample_valid   = '0;
        bus.sensor_timeout = '0;
    endtask

    task automatic chk_now(input string name, input logic [EXP_W:0] act,
                           input logic [EXP_W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] a;
        step_no = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_no++;
                a = {bus.near_flag, bus.far_flag, bus.closest_valid, bus.closest_ch};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL step%0d outputs: got near=%b far=%b cv=%b cch=%0d expected near=%b far=%b cv=%b cch=%0d",
                             step_no, a[10:7], a[6:3], a[2], a[1:0], e[10:7], e[6:3], e[2], e[1:0]);
                end
                checks++;
                if (bus.object_detected !== (|e[10:7])) begin
                    errors++;
                    $display("FAIL step%0d object_detected: got %b expected %b",
                             step_no, bus.object_detected, |e[10:7]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.time_taken     = '0;
        bus.sample_valid   = '0;
        bus.sensor_timeout = '0;
        #2;
        chk_now("reset_outputs",
                {bus.object_detected, bus.near_flag, bus.far_flag, bus.closest_valid, bus.closest_ch},
                12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 debounce: 2,2 -> FAR then NEAR, closest one cycle later
        put(0, 2); cyc(4'b0000, 4'b0001, 1'b0, 2'd0);
        put(0, 2); cyc(4'b0001, 4'b0000, 1'b0, 2'd0);
        cyc(4'b0001, 4'b0000, 1'b1, 2'd0);

        // ch1 into NEAR, then 4 (hold by hysteresis), then 6 (exit)
        put(1, 3); cyc(4'b0001, 4'b0010, 1'b1, 2'd0);
        put(1, 3); cyc(4'b0011, 4'b0000, 1'b1, 2'd0);
        put(1, 4); cyc(4'b0011, 4'b0000, 1'b1, 2'd0);
        put(1, 6); cyc(4'b0001, 4'b0010, 1'b1, 2'd0);
        cyc(4'b0001, 4'b0010, 1'b1, 2'd0);
        // ch0 leaves NEAR -> no object
        put(0, 9); cyc(4'b0000, 4'b0011, 1'b1, 2'd0);
        cyc(4'b0000, 4'b0011, 1'b0, 2'd0);

        // ch2: 1, 7, 1 never reaches NEAR
        put(2, 1); cyc(4'b0000, 4'b0111, 1'b0, 2'd0);
        put(2, 7); cyc(4'b0000, 4'b0111, 1'b0, 2'd0);
        put(2, 1); cyc(4'b0000, 4'b0111, 1'b0, 2'd0);
        cyc(4'b0000, 4'b0111, 1'b0, 2'd0);

        // clear all channels by timeout
        bus.sensor_timeout = 4'b1111; cyc(4'b0000, 4'b0000, 1'b0, 2'd0);

        // ch0 NEAR at 3, ch2 NEAR at 1 -> closest 2; then tie 2/2 -> 0
        put(0, 3); put(2, 1); cyc(4'b0000, 4'b0101, 1'b0, 2'd0);
        put(0, 3); put(2, 1); cyc(4'b0101, 4'b0000, 1'b0, 2'd0);
        cyc(4'b0101, 4'b0000, 1'b1, 2'd2);
        put(0, 2); put(2, 2); cyc(4'b0101, 4'b0000, 1'b1, 2'd2);
        cyc(4'b0101, 4'b0000, 1'b1, 2'd0);
        // drop ch0 then ch2; closest_ch holds 2 after the last NEAR leaves
        put(0, 9); cyc(4'b0100, 4'b0001, 1'b1, 2'd0);
        cyc(4'b0100, 4'b0001, 1'b1, 2'd2);
        put(2, 8); cyc(4'b0000, 4'b0101, 1'b1, 2'd2);
        cyc(4'b0000, 4'b0101, 1'b0, 2'd2);
        bus.sensor_timeout = 4'b0101; cyc(4'b0000, 4'b0000, 1'b0, 2'd2);

        // ch3 NEAR, then 16 empty cycles -> IDLE on the 16th
        put(3, 0); cyc(4'b0000, 4'b1000, 1'b0, 2'd2);
        put(3, 0); cyc(4'b1000, 4'b0000, 1'b0, 2'd2);
        for (int k = 0; k < 15; k++) cyc(4'b1000, 4'b0000, 1'b1, 2'd3);
        cyc(4'b0000, 4'b0000, 1'b1, 2'd3);
        cyc(4'b0000, 4'b0000, 1'b0, 2'd3);

        // ch1 NEAR, then timeout together with a time-0 sample -> IDLE
        put(1, 1); cyc(4'b0000, 4'b0010, 1'b0, 2'd3);
        put(1, 1); cyc(4'b0010, 4'b0000, 1'b0, 2'd3);
        put(1, 0); bus.sensor_timeout = 4'b0010; cyc(4'b0000, 4'b0000, 1'b1, 2'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 2'd1);

        // ch0 NEAR, then asynchronous reset mid-cycle
        put(0, 0); cyc(4'b0000, 4'b0001, 1'b0, 2'd1);
        put(0, 0); cyc(4'b0001, 4'b0000, 1'b0, 2'd1);
        cyc(4'b0001, 4'b0000, 1'b1, 2'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_now("async_reset_outputs",
                {bus.object_detected, bus.near_flag, bus.far_flag, bus.closest_valid, bus.closest_ch},
                12'h000);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
